// File: rtl/hd_word_loader.sv
// Byte-stream to 32-bit operand packer for the Hacker's-Delight kernels.
// Beats pack LSB-first; short words close early on in_last and are padded.
module hd_word_loader #(
    parameter int IN_W    = 8,
    parameter int WORD_W  = 32,
    parameter bit PAD_BIT = 1'b0,
    parameter int CNT_W   = 16,
    localparam int BEATS  = WORD_W / IN_W,
    localparam int BW     = $clog2(BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [BW-1:0]     out_beats,
    output logic              out_padded,
    output logic [CNT_W-1:0]  word_count
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [WORD_W-1:0] PAD_WORD = {WORD_W{PAD_BIT}};

    logic [WORD_W-1:0] asm_q, asm_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic [BW-1:0]     out_beats_q, out_beats_d;
    logic              out_padded_q, out_padded_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;

    logic [WORD_W-1:0] merged;
    logic              accept;
    logic              last_beat;
    logic              complete;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign complete  = accept && (last_beat || in_last);

    // Upper beats are already PAD_BIT because asm restarts padded.
    always_comb begin
        merged = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CW'(b)) begin
                merged[b*IN_W +: IN_W] = in_data;
            end
        end
    end

    always_comb begin
        asm_d        = asm_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_beats_d  = out_beats_q;
        out_padded_d = out_padded_q;
        word_count_d = word_count_q;
        if (complete) begin
            out_word_d   = merged;
            out_valid_d  = 1'b1;
            out_beats_d  = BW'(cnt_q) + BW'(1);
            out_padded_d = !last_beat;
            cnt_d        = '0;
            asm_d        = PAD_WORD;
            word_count_d = word_count_q + CNT_W'(1);
        end else begin
            if (accept) begin
                asm_d = merged;
                cnt_d = cnt_q + CW'(1);
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q        <= PAD_WORD;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_beats_q  <= '0;
            out_padded_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            asm_q        <= asm_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_beats_q  <= out_beats_d;
            out_padded_q <= out_padded_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign out_beats  = out_beats_q;
    assign out_padded = out_padded_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_hd_word_loader.sv
// Scoreboard bench for hd_word_loader: default instance plus a
// PAD_BIT=1, CNT_W=2 instance for padding and counter wrap.
module tb_hd_word_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [2:0]  out_beats;
    logic        out_padded;
    logic [15:0] word_count;

    logic        p_in_valid = 1'b0;
    logic        p_in_ready;
    logic [7:0]  p_in_data = '0;
    logic        p_in_last = 1'b0;
    logic        p_out_valid;
    logic [31:0] p_out_word;
    logic [2:0]  p_out_beats;
    logic        p_out_padded;
    logic [1:0]  p_word_count;

    always #5 clk = ~clk;

    hd_word_loader dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_beats(out_beats),
        .out_padded(out_padded), .word_count(word_count)
    );

    hd_word_loader #(.PAD_BIT(1'b1), .CNT_W(2)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_data(p_in_data), .in_last(p_in_last),
        .out_valid(p_out_valid), .out_ready(1'b1),
        .out_word(p_out_word), .out_beats(p_out_beats),
        .out_padded(p_out_padded), .word_count(p_word_count)
    );

    typedef struct {
        logic [31:0] w;
        logic [2:0]  b;
        logic        p;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_buf = '0;
    int          m_cnt = 0;
    int          m_wc = 0;
    int          drops = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one beat from a negedge; returns at the negedge after accept.
    task automatic put(input logic [7:0] d, input logic l);
        logic r;
        bit   ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int n = 0; n < 50; n++) begin
            #1;
            r = in_ready;
            if (!r) drops++;
            @(negedge clk);
            if (r) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        m_buf[m_cnt*8 +: 8] = d;
        if (m_cnt == 3 || l) begin
            sb.push_back('{w: m_buf, b: 3'(m_cnt + 1), p: (m_cnt != 3)});
            m_buf = '0;
            m_cnt = 0;
            m_wc++;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        m_buf = '0;
        m_cnt = 0;
        m_wc  = 0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_word", out_word, 32'd0);
        check("rst_beats", {29'd0, out_beats}, 32'd0);
        check("rst_padded", {31'd0, out_padded}, 32'd0);
        check("rst_count", {16'd0, word_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pput(input logic [7:0] d, input logic l);
        p_in_valid = 1'b1;
        p_in_data  = d;
        p_in_last  = l;
        @(posedge clk);
        #1;
        p_in_valid = 1'b0;
        p_in_last  = 1'b0;
        @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", out_word, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word", out_word, e.w);
                check("beats", {29'd0, out_beats}, {29'd0, e.b});
                check("padded", {31'd0, out_padded}, {31'd0, e.p});
            end
        end
    end

    initial begin
        do_reset();

        out_ready = 1'b1;
        put(8'h01, 0); put(8'h02, 0); put(8'h04, 0); put(8'h80, 0);
        idle();
        @(negedge clk); #1;
        check("one_cycle_valid", {31'd0, out_valid}, 32'd0);
        check("count_1", {16'd0, word_count}, m_wc);

        put(8'hAA, 0); put(8'h55, 1);
        put(8'h10, 0); put(8'h20, 0); put(8'h30, 0); put(8'h40, 0);
        idle();
        repeat (2) @(negedge clk);

        out_ready = 1'b0;
        put(8'hA1, 0); put(8'hA2, 0); put(8'hA3, 0); put(8'hA4, 1);
        idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_word", out_word, 32'hA4A3A2A1);
        end
        out_ready = 1'b1;
        put(8'h44, 0); put(8'h33, 0); put(8'h22, 0); put(8'h11, 0);
        idle();
        repeat (2) @(negedge clk);

        do_reset();
        drops = 0;
        for (int i = 0; i < 8; i++) put(8'(i), 0);
        idle();
        repeat (2) @(negedge clk); #1;
        check("b2b_ready_drops", drops, 32'd0);
        check("b2b_count", {16'd0, word_count}, 32'd2);

        put(8'h99, 0); put(8'h98, 0);
        idle();
        do_reset();
        out_ready = 1'b0;
        put(8'h01, 0); put(8'h02, 0); put(8'h03, 0); put(8'h04, 0);
        idle();
        do_reset();
        out_ready = 1'b1;
        put(8'hDE, 0); put(8'hAD, 0); put(8'hBE, 0); put(8'hEF, 0);
        idle();
        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        pput(8'h3C, 1);
        check("pad_word", p_out_word, 32'hFFFFFF3C);
        check("pad_beats", {29'd0, p_out_beats}, 32'd1);
        check("pad_padded", {31'd0, p_out_padded}, 32'd1);
        check("pad_valid", {31'd0, p_out_valid}, 32'd1);
        pput(8'h5A, 0);
        pput(8'h6B, 1);
        check("pad2_word", p_out_word, 32'hFFFF6B5A);
        check("pad2_beats", {29'd0, p_out_beats}, 32'd2);
        pput(8'h01, 1); pput(8'h02, 1); pput(8'h03, 1);
        check("wrap_count", {30'd0, p_word_count}, 32'd1);
        check("wrap_word", p_out_word, 32'hFFFFFF03);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
